// File: rtl/insn_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : insn_prefetch
// Brief    : Instruction prefetch queue. Issues sequential word reads to a
//            synchronous-read instruction memory, buffers {pc, insn} pairs in
//            a small FIFO and hands them to the front end over valid/ready.
//            A redirect flushes the queue, drops the outstanding read and
//            restarts fetching at the new PC.
// Revision : 1.0 - initial release
// ============================================================================
module insn_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_insn,
    output logic [31:0] out_pc
);

    // Pointer width covers DEPTH entries; occupancy needs one extra bit to
    // represent the completely full state.
    localparam int unsigned c_PTR_W = $clog2(DEPTH);
    localparam int unsigned c_OCC_W = c_PTR_W + 1;
    localparam logic [c_OCC_W-1:0] c_DEPTH_OCC = c_OCC_W'(DEPTH);

    // Pointers rely on natural binary wrap, so DEPTH must be a power of two.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("insn_prefetch: DEPTH must be a power of two and at least 2");
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [31:0]        r_fetch_pc;
    logic               r_inflight;
    logic [31:0]        r_inflight_pc;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_OCC_W-1:0] r_occ;
    logic [31:0]        r_pc_q   [DEPTH];
    logic [31:0]        r_insn_q [DEPTH];

    // ------------------------------------------------------------------------
    // Handshake and credit logic
    // ------------------------------------------------------------------------
    logic               w_pop;
    logic               w_push;
    logic               w_credit;
    logic [c_OCC_W:0]   w_committed;

    assign out_valid = (r_occ != '0);
    assign w_pop     = out_valid && out_ready;

    // A response is only kept when no redirect is flushing the queue.
    assign w_push    = r_inflight && !redirect_valid;

    // Every slot is either occupied or promised to the outstanding read;
    // a fresh read may only go out if one slot is uncommitted, or if the
    // head is leaving this cycle and frees one.
    assign w_committed = {1'b0, r_occ} + {{c_OCC_W{1'b0}}, r_inflight};
    assign w_credit    = (w_committed < {1'b0, c_DEPTH_OCC});

    assign mem_rd   = !rst && !redirect_valid && (w_credit || w_pop);
    assign mem_addr = r_fetch_pc;

    // Head entry is forced to zero while empty so reset shows clean outputs.
    assign out_insn = out_valid ? r_insn_q[r_rd_ptr] : 32'h0;
    assign out_pc   = out_valid ? r_pc_q[r_rd_ptr]   : 32'h0;

    // ------------------------------------------------------------------------
    // Fetch address and outstanding-read tracking
    // ------------------------------------------------------------------------
    // Advance the fetch PC on every issued read; a redirect overrides it and
    // forgets the in-flight read so its response is never captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'h0;
        end else if (redirect_valid) begin
            r_fetch_pc    <= redirect_pc;
            r_inflight    <= 1'b0;
        end else begin
            r_inflight <= mem_rd;
            if (mem_rd) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ------------------------------------------------------------------------
    // A redirect empties the queue outright; a pop in the same cycle is
    // already complete on the consumer side, so nothing else is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_occ    <= '0;
        end else if (redirect_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------------
    // Payload storage needs no reset: entries are only observed once the
    // occupancy counter says they were written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_q[r_wr_ptr]   <= r_inflight_pc;
            r_insn_q[r_wr_ptr] <= mem_data;
        end
    end

    // ------------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------------
    // The credit rule must make a write into a full queue impossible.
    a_no_full_write: assert property (@(posedge clk) disable iff (rst)
        !(w_push && (r_occ == c_DEPTH_OCC)));

    // At most one read is ever outstanding on top of the stored entries.
    a_committed_bound: assert property (@(posedge clk) disable iff (rst)
        (w_committed <= {1'b0, c_DEPTH_OCC}));

endmodule
`default_nettype wire

// File: tb/tb_insn_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_insn_prefetch
// Brief    : Self-checking bench for insn_prefetch. Directed scenarios plus a
//            randomized phase, all checked against a stream-level model:
//            delivered PCs run sequentially from the last restart point, the
//            queue is empty for exactly the restart latency and never bubbles
//            afterwards, and issued addresses run sequentially as well.
// Revision : 1.0 - initial release
// ============================================================================
module tb_insn_prefetch;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_insn;
    logic [31:0] out_pc;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Stream-level reference state
    logic [31:0] exp_pc;      // pc of the next instruction the consumer must see
    logic [31:0] exp_fetch;   // address of the next read that must be issued
    int          since;       // cycles since the stream last (re)started
    int          delivered;
    logic [31:0] popped [$];

    insn_prefetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_rd         (mem_rd),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_insn       (out_insn),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    // Memory image: word a holds 0xA0 + a (so words 0..5 are 0xA0..0xA5).
    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return a + 32'hA0;
    endfunction

    // Synchronous-read instruction memory.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= insn_of(mem_addr);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle. Called just after a falling edge with inputs set;
    // evaluates the model before the rising edge, returns at the next fall.
    task automatic tick();
        #1;
        if (rst) begin
            check_eq("rst_mem_rd", 32'(mem_rd), 32'd0);
            check_eq("rst_out_valid", 32'(out_valid), 32'd0);
            exp_pc    = RESET_PC;
            exp_fetch = RESET_PC;
            since     = 0;
        end else begin
            check_eq("out_valid_timing", 32'(out_valid), 32'(since >= 3));
            if (out_valid && out_ready) begin
                check_eq("pop_pc", out_pc, exp_pc);
                check_eq("pop_insn", out_insn, insn_of(exp_pc));
                popped.push_back(out_pc);
                exp_pc = exp_pc + 32'd1;
                delivered++;
            end
            if (redirect_valid) begin
                check_eq("redirect_mem_rd", 32'(mem_rd), 32'd0);
                exp_pc    = redirect_pc;
                exp_fetch = redirect_pc;
                since     = 0;
            end else begin
                if (out_ready || !out_valid) check_eq("issue_expected", 32'(mem_rd), 32'd1);
                if (mem_rd) begin
                    check_eq("fetch_addr", mem_addr, exp_fetch);
                    exp_fetch = exp_fetch + 32'd1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (since < 1000) since++;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    logic [31:0] wrap_exp [4];

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b1;
        exp_pc         = RESET_PC;
        exp_fetch      = RESET_PC;
        since          = 0;
        delivered      = 0;
        wrap_exp[0] = 32'hFFFF_FFFE;
        wrap_exp[1] = 32'hFFFF_FFFF;
        wrap_exp[2] = 32'h0000_0000;
        wrap_exp[3] = 32'h0000_0001;

        // Reset values
        @(negedge clk);
        #1;
        check_eq("rst_mem_addr", mem_addr, RESET_PC);
        check_eq("rst_out_insn", out_insn, 32'h0);
        check_eq("rst_out_pc", out_pc, 32'h0);
        tick();
        tick();

        // Stream: first instruction visible in C2, then one per cycle
        rst = 1'b0;
        #1;
        check_eq("c0_mem_rd", 32'(mem_rd), 32'd1);
        check_eq("c0_mem_addr", mem_addr, RESET_PC);
        delivered = 0;
        repeat (9) tick();
        check_eq("stream_count", 32'(delivered), 32'd7);

        // Backpressure: fill to DEPTH, then fetch stalls at pc 4
        do_reset();
        out_ready = 1'b0;
        repeat (10) tick();
        #1;
        check_eq("bp_mem_rd", 32'(mem_rd), 32'd0);
        check_eq("bp_mem_addr", mem_addr, 32'd4);
        check_eq("bp_head_pc", out_pc, 32'd0);
        out_ready = 1'b1;
        #1;
        check_eq("bp_resume_rd", 32'(mem_rd), 32'd1);
        delivered = 0;
        repeat (6) tick();
        check_eq("bp_count", 32'(delivered), 32'd6);

        // Redirect while two entries are queued and one read is in flight
        do_reset();
        out_ready = 1'b0;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        tick();
        redirect_valid = 1'b0;
        #1;
        check_eq("rdr_flushed", 32'(out_valid), 32'd0);
        check_eq("rdr_issue_addr", mem_addr, 32'h20);
        out_ready = 1'b1;
        tick();
        tick();
        #1;
        check_eq("rdr_first_valid", 32'(out_valid), 32'd1);
        check_eq("rdr_first_pc", out_pc, 32'h20);
        repeat (3) tick();

        // Redirect coincident with a pop from a full queue
        do_reset();
        out_ready = 1'b0;
        repeat (10) tick();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        delivered      = 0;
        tick();
        redirect_valid = 1'b0;
        check_eq("rpf_head_delivered", 32'(delivered), 32'd1);
        #1;
        check_eq("rpf_flushed", 32'(out_valid), 32'd0);
        repeat (5) tick();

        // Asynchronous reset between edges with three entries queued
        do_reset();
        out_ready = 1'b0;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_mem_rd", 32'(mem_rd), 32'd0);
        check_eq("arst_mem_addr", mem_addr, RESET_PC);
        @(negedge clk);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        check_eq("arst_restart_addr", mem_addr, RESET_PC);
        repeat (6) tick();

        // PC wrap across 2^32
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        popped.delete();
        for (int i = 0; i < 20 && popped.size() < 4; i++) tick();
        check_eq("wrap_count", 32'(popped.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_eq("wrap_pc", (popped.size() > i) ? popped[i] : 32'hDEAD_BEEF, wrap_exp[i]);
        end

        // Randomized traffic: ready, redirects and occasional resets
        for (int i = 0; i < 1500; i++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 2))
                0:       redirect_pc = $urandom;
                1:       redirect_pc = 32'hFFFF_FFFF - $urandom_range(0, 5);
                default: redirect_pc = $urandom_range(0, 255);
            endcase
            if ($urandom_range(0, 299) == 0) rst = 1'b1;
            tick();
            rst = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
